// File: rtl/lsu_mem_master.sv
// ============================================================================
// lsu_mem_master : CPU load/store unit to 16-bit memory master
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_mem_master #(
  parameter int READ_LAT = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic        ReqByte,
  input  logic        ReqSigned,
  input  logic [15:0] ReqAddr,
  input  logic [15:0] ReqWData,
  output logic        RespValid,
  output logic [15:0] RespData,
  output logic        RespErr,
  output logic [15:0] Adresa,
  output logic [15:0] WriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [15:0] ReadData
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        write_q, write_d, byte_q, byte_d, signed_q, signed_d;
  logic        sel_q, sel_d, err_q, err_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic [15:0] data_q, data_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [15:0] resp_data_q, resp_data_d, addr_q, addr_d, wdata_q, wdata_d;
  logic        mem_write_q, mem_write_d, mem_read_q, mem_read_d;
  logic [7:0]  sel_byte;

  assign sel_byte = sel_q ? data_q[15:8] : data_q[7:0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    byte_d       = byte_q;
    signed_d     = signed_q;
    sel_d        = sel_q;
    err_d        = err_q;
    wbyte_d      = wbyte_q;
    data_d       = data_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          write_d  = ReqWrite;
          byte_d   = ReqByte;
          signed_d = ReqSigned;
          sel_d    = ReqAddr[0];
          wbyte_d  = ReqWData[7:0];
          err_d    = ~ReqByte & ReqAddr[0];
          if (~ReqByte & ReqAddr[0]) begin
            state_d = RESP;
          end else begin
            addr_d = {ReqAddr[15:1], 1'b0};
            if (ReqWrite && !ReqByte) begin
              state_d     = WR;
              mem_write_d = 1'b1;
              wdata_d     = ReqWData;
            end else begin
              state_d    = RD;
              mem_read_d = 1'b1;
              cnt_d      = LAT_M1;
            end
          end
        end
      end
      RD: begin
        if (cnt_q == 2'd0) begin
          data_d = ReadData;
          if (write_q) begin
            // Byte store: merge the new byte into the word just read
            state_d     = WR;
            mem_write_d = 1'b1;
            wdata_d     = sel_q ? {wbyte_q, ReadData[7:0]} : {ReadData[15:8], wbyte_q};
          end else begin
            state_d = RESP;
          end
        end else begin
          cnt_d      = cnt_q - 2'd1;
          mem_read_d = 1'b1;
        end
      end
      WR: state_d = RESP;
      RESP: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        if (err_q || write_q)
          resp_data_d = 16'h0000;
        else if (byte_q)
          resp_data_d = {{8{signed_q & sel_byte[7]}}, sel_byte};
        else
          resp_data_d = data_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      signed_q     <= 1'b0;
      sel_q        <= 1'b0;
      err_q        <= 1'b0;
      wbyte_q      <= 8'h00;
      data_q       <= 16'h0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 16'h0000;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      byte_q       <= byte_d;
      signed_q     <= signed_d;
      sel_q        <= sel_d;
      err_q        <= err_d;
      wbyte_q      <= wbyte_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
    end
  end

  assign ReqReady  = (state_q == IDLE);
  assign RespValid = resp_valid_q;
  assign RespData  = resp_data_q;
  assign RespErr   = resp_err_q;
  assign Adresa    = addr_q;
  assign WriteData = wdata_q;
  assign MemWrite  = mem_write_q;
  assign MemRead   = mem_read_q;

endmodule

`default_nettype wire
